regfile_write_arbiter: RTL and testbench

Two-requester write-back arbiter that owns the single write port of `register_file`. It accepts write requests from the ALU (requester 0) and the load unit (requester 1) over valid/ready handshakes. Each cycle it grants at most one request and drives `write_enable`/`write_destination`/`write_data` from a registered output stage. It sits between the execute/memory stages and `register_file`, and also keeps a saturating count of contention cycles for debug.

---
 rtl/corg_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/corg_pkg.sv
// -----------------------------------------------------------------------------
// corg_pkg
// Shared constants and types for the register-file write-back path.
//   DATA_W / ADDR_W / CNT_W : default widths (16-bit word, 8 registers,
//                             8-bit contention counter)
//   REQ_ALU / REQ_LOAD      : requester indices (0 = ALU, 1 = load unit)
//   grant_state_e           : two-state "who was granted last" encoding
// -----------------------------------------------------------------------------
package corg_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  // State value equals the index of the most recently granted requester.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } grant_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way grant for the write-back arbiter.
// Tie-break policy selected by macro REGFILE_ARB_RR_EN:
//   defined     : round-robin, a tie goes to the requester that is not
//                 last_grant_i
//   not defined : fixed priority, a tie always goes to requester 1 (load)
// Ports:
//   valid0_i, valid1_i : request valids
//   last_grant_i       : index of the most recently granted requester
//   stall_i            : hold, no grant while 1
//   grant0_o, grant1_o : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2
  import corg_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  input  logic stall_i,
  output logic grant0_o,
  output logic grant1_o
);

`ifndef REGFILE_ARB_RR_EN
  // Fixed priority never consults the history bit.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (!stall_i) begin
      if (valid0_i && valid1_i) begin
`ifdef REGFILE_ARB_RR_EN
        if (last_grant_i == REQ_LOAD) begin
          grant0_o = 1'b1;
        end else begin
          grant1_o = 1'b1;
        end
`else
        grant1_o = 1'b1;
`endif
      end else begin
        grant0_o = valid0_i;
        grant1_o = valid1_i;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of register_file. Arbitrates between the ALU
// (requester 0) and the load unit (requester 1) over valid/ready, and drives
// the register-file write port from a registered output stage (one cycle
// latency). Also keeps a saturating count of contention cycles for debug.
// Tie-break policy: macro REGFILE_ARB_RR_EN (round-robin when defined,
// fixed priority to the load unit otherwise).
// Ports:
//   clk, rst (synchronous, active-low), stall (no grants while 1)
//   req0_valid/dest/data/ready : ALU request channel
//   req1_valid/dest/data/ready : load-unit request channel
//   write_enable/destination/data : register-file write port
//   last_grant     : index of the most recently granted requester
//   conflict_count : saturating count of cycles with both valid and no stall
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = corg_pkg::DATA_W,
  parameter int ADDR_W = corg_pkg::ADDR_W,
  parameter int CNT_W  = corg_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_dest,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_dest,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_destination,
  output logic [DATA_W-1:0] write_data,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  corg_pkg::grant_state_e state_q, state_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      dest_q, dest_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic grant0, grant1;
  logic xfer0, xfer1;
  logic contention;

  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant),
    .stall_i      (stall),
    .grant0_o     (grant0),
    .grant1_o     (grant1)
  );

  assign req0_ready = grant0 && !stall;
  assign req1_ready = grant1 && !stall;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign contention = req0_valid && req1_valid && !stall;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    dest_d  = dest_q;   // address/data hold when idle
    data_d  = data_q;
    if (xfer1) begin
      we_d    = 1'b1;
      dest_d  = req1_dest;
      data_d  = req1_data;
      state_d = corg_pkg::LAST1;
    end else if (xfer0) begin
      we_d    = 1'b1;
      dest_d  = req0_dest;
      data_d  = req0_data;
      state_d = corg_pkg::LAST0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (contention && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= corg_pkg::LAST1;  // requester 0 wins the first tie
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A write sitting in the output stage while reset is asserted must not
  // reach the register file, so the enable is also qualified by rst.
  assign write_enable      = we_q && rst;
  assign write_destination = dest_q;
  assign write_data        = data_q;
  assign last_grant        = (state_q == corg_pkg::LAST1);
  assign conflict_count    = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [2:0]  d0 = '0, d1 = '0;
  logic [15:0] x0 = '0, x1 = '0;
  logic        r0, r1, we, lg;
  logic [2:0]  wd;
  logic [15:0] wdata;
  logic [7:0]  cc;

  int checks = 0;
  int failures = 0;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  // Register-file model fed by the write port.
  logic [15:0] rf [0:7] = '{default: 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we === 1'b1) rf[wd] <= wdata;
  end

  regfile_write_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .req0_valid        (v0),
    .req0_dest         (d0),
    .req0_data         (x0),
    .req0_ready        (r0),
    .req1_valid        (v1),
    .req1_dest         (d1),
    .req1_data         (x1),
    .req1_ready        (r1),
    .write_enable      (we),
    .write_destination (wd),
    .write_data        (wdata),
    .last_grant        (lg),
    .conflict_count    (cc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; stall = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic g;

    // Reset: two cycles low with both requesters valid.
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
    d0 = 3'd2; x0 = 16'hA357; d1 = 3'd3; x1 = 16'h1234;
    tick();
    tick();
    check("rst_we", we, 0);
    check("rst_cnt", cc, 0);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    tick();
    check("post_rst_we", we, 0);
    check("post_rst_cnt", cc, 0);
    check("post_rst_lg", lg, 1);

    // Single request from the ALU.
    v0 = 1'b1; d0 = 3'd1; x0 = 16'h09A5;
    #1;
    check("single_r0", r0, 1);
    check("single_r1", r1, 0);
    tick();
    v0 = 1'b0;
    check("single_we", we, 1);
    check("single_dest", wd, 1);
    check("single_data", wdata, 16'h09A5);
    check("single_lg", lg, 0);
    tick();
    check("single_rf1", rf[1], 16'h09A5);
    check("single_we_off", we, 0);

    // Tie: both valid for four cycles, starting with last_grant=1.
    do_reset();
    v0 = 1'b1; d0 = 3'd2; x0 = 16'hA357;
    v1 = 1'b1; d1 = 3'd3; x1 = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      g = RR_BUILD ? ((i % 2) == 1) : 1'b1;
      #1;
      check("tie_r0", r0, !g);
      check("tie_r1", r1, g);
      tick();
      check("tie_lg", lg, g);
      check("tie_dest", wd, g ? 3'd3 : 3'd2);
      check("tie_data", wdata, g ? 16'h1234 : 16'hA357);
    end
    check("tie_cnt", cc, 4);

    // Stall for three cycles with both still valid.
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("stall_r0", r0, 0);
      check("stall_r1", r1, 0);
      check("stall_we", we, (s == 0));
      tick();
    end
    stall = 1'b0;
    #1;
    check("unstall_we", we, 0);
    check("unstall_cnt", cc, 4);
    check("unstall_r0", r0, RR_BUILD);
    check("unstall_r1", r1, !RR_BUILD);
    tick();
    check("resume_we", we, 1);
    check("resume_cnt", cc, 5);
    v0 = 1'b0; v1 = 1'b0;

    // Same destination from both requesters.
    do_reset();
    v0 = 1'b1; d0 = 3'd5; x0 = 16'h0001;
    v1 = 1'b1; d1 = 3'd5; x1 = 16'h0002;
    #1;
    check("same_r0_first", r0, RR_BUILD);
    tick();
    check("same_dest_first", wd, 5);
    check("same_data_first", wdata, RR_BUILD ? 16'h0001 : 16'h0002);
    v0 = !RR_BUILD;
    v1 = RR_BUILD;
    #1;
    check("same_r0_second", r0, !RR_BUILD);
    check("same_r1_second", r1, RR_BUILD);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    check("same_we_second", we, 1);
    check("same_data_second", wdata, RR_BUILD ? 16'h0002 : 16'h0001);
    tick();
    check("same_rf5", rf[5], RR_BUILD ? 16'h0002 : 16'h0001);
    check("same_we_off", we, 0);

    // Counter saturation over 300 contention cycles.
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254) check("sat_254", cc, 8'hFE);
      if (k == 255) check("sat_255", cc, 8'hFF);
      if (k == 300) check("sat_300", cc, 8'hFF);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // Reset asserted in the cycle after a grant.
    v0 = 1'b1; d0 = 3'd6; x0 = 16'hBEEF;
    #1;
    check("rstw_r0", r0, 1);
    tick();
    rst = 1'b0; v0 = 1'b0;
    #1;
    check("rstw_we_now", we, 0);
    tick();
    check("rstw_we_next", we, 0);
    check("rstw_lg", lg, 1);
    check("rstw_cnt", cc, 0);
    rst = 1'b1;
    tick();
    check("rstw_rf6", rf[6], 16'h0000);
    check("rstw_we_after", we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
